// File: rtl/store_buffer_if.sv
// ============================================================================
// Module  : store_buffer_if
// Purpose : Pipeline-side and data_mem-side signals of the store buffer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface store_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cpu_mem_write;
    logic              cpu_mem_read;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_write_data;
    logic [DATA_W-1:0] cpu_read_data;
    logic              cpu_stall;
    logic              buf_empty;
    logic              dm_MemWrite;
    logic              dm_MemRead;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_WriteData;
    logic [DATA_W-1:0] dm_ReadData;

    modport slave (
        input  cpu_mem_write, cpu_mem_read, cpu_address, cpu_write_data, dm_ReadData,
        output cpu_read_data, cpu_stall, buf_empty,
               dm_MemWrite, dm_MemRead, dm_address, dm_WriteData
    );

    modport master (
        output cpu_mem_write, cpu_mem_read, cpu_address, cpu_write_data, dm_ReadData,
        input  cpu_read_data, cpu_stall, buf_empty,
               dm_MemWrite, dm_MemRead, dm_address, dm_WriteData
    );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module  : store_buffer
// Purpose : Posted-write queue between EX/MEM and data_mem with load forwarding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input wire            clk,
    input wire            rst,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_store;
    logic              w_load;
    logic              w_push;
    logic              w_drain;
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd;
    logic [PTR_W-1:0]  w_idx;

    // Requests are masked during reset so every output reads as idle.
    assign w_full  = (r_count == C_FULL);
    assign w_store = bus.cpu_mem_write & ~rst;
    assign w_load  = bus.cpu_mem_read & ~bus.cpu_mem_write & ~rst;
    assign w_push  = w_store & ~w_full;
    assign w_drain = (r_count != '0) & ~w_load & (~w_store | w_full);

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr[w_idx] == bus.cpu_address)) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    assign bus.cpu_read_data = w_load ? (w_hit ? w_fwd : bus.dm_ReadData) : '0;
    assign bus.cpu_stall     = w_store & w_full;
    assign bus.buf_empty     = (r_count == '0);
    assign bus.dm_MemRead    = w_load;
    assign bus.dm_MemWrite   = w_drain;
    assign bus.dm_address    = w_load  ? bus.cpu_address :
                               w_drain ? r_addr[r_head]  : '0;
    assign bus.dm_WriteData  = w_drain ? r_data[r_head] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_drain) begin
                r_count <= r_count + 1'b1;
            end else if (w_drain && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.cpu_address;
            r_data[r_tail] <= bus.cpu_write_data;
        end
    end
endmodule

`default_nettype wire
